// File: rtl/cmd_agg_pkg.sv
// Shared types and sizes for the UART command aggregator.
package cmd_agg_pkg;
  typedef enum logic [1:0] {IDLE, GOT1, GOT2, FULL} rx_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;
  localparam int CMD_BYTES = 3;
  localparam int CMD_W     = 24;
endpackage

// File: rtl/cmd_resp_tx.sv
// Response path: latches one byte per send_resp, strobes the UART transmitter
// and reports completion once the transmitter raises tx_done.
module cmd_resp_tx
  import cmd_agg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] resp_data,
  input  logic       send_resp,
  output logic       resp_sent,
  output logic [7:0] tx_data,
  output logic       trmt,
  input  logic       tx_done
);
  tx_state_t  state, state_nxt;
  logic [7:0] data_nxt;
  logic       trmt_nxt, sent_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= TX_IDLE;
      tx_data   <= '0;
      trmt      <= 1'b0;
      resp_sent <= 1'b0;
    end else begin
      state     <= state_nxt;
      tx_data   <= data_nxt;
      trmt      <= trmt_nxt;
      resp_sent <= sent_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    data_nxt  = tx_data;
    trmt_nxt  = 1'b0;
    sent_nxt  = 1'b0;
    case (state)
      TX_IDLE: if (send_resp) begin
        data_nxt  = resp_data;
        trmt_nxt  = 1'b1;
        state_nxt = TX_BUSY;
      end
      // tx_done may still be stale from the previous byte while trmt is high
      TX_BUSY: if (tx_done && !trmt) begin
        sent_nxt  = 1'b1;
        state_nxt = TX_IDLE;
      end
      default: state_nxt = TX_IDLE;
    endcase
  end
endmodule

// File: rtl/cmd_aggregator.sv
// Assembles three UART bytes into a 24-bit command with an inter-byte
// timeout, and forwards response bytes to the UART transmitter.
module cmd_aggregator
  import cmd_agg_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_rdy,
  output logic             clr_rx_rdy,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  output logic             frame_err,
  input  logic [7:0]       resp_data,
  input  logic             send_resp,
  output logic             resp_sent,
  output logic [7:0]       tx_data,
  output logic             trmt,
  input  logic             tx_done
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  rx_state_t        state, state_nxt;
  logic [15:0]      part, part_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CMD_W-1:0] cmd_nxt;
  logic             err_nxt, accept, expire;

  // Holding off in FULL back-pressures the receiver; no byte is consumed in reset.
  assign accept     = rx_rdy && (state != FULL) && !rst;
  assign clr_rx_rdy = accept;
  assign cmd_rdy    = (state == FULL);
  assign expire     = (state == GOT1 || state == GOT2) && (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      part      <= '0;
      cnt       <= '0;
      cmd       <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      part      <= part_nxt;
      cnt       <= cnt_nxt;
      cmd       <= cmd_nxt;
      frame_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    part_nxt  = part;
    cnt_nxt   = cnt;
    cmd_nxt   = cmd;
    err_nxt   = 1'b0;
    if (state == FULL) begin
      if (clr_cmd_rdy) state_nxt = IDLE;
    end else if (accept) begin
      cnt_nxt = '0;
      if (state == GOT2) begin
        cmd_nxt   = {part, rx_data};
        part_nxt  = '0;
        state_nxt = FULL;
      end else begin
        part_nxt  = {part[7:0], rx_data};
        state_nxt = (state == IDLE) ? GOT1 : GOT2;
      end
    end else if (expire) begin
      state_nxt = IDLE;
      part_nxt  = '0;
      cnt_nxt   = '0;
      err_nxt   = 1'b1;
    end else if (state != IDLE) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  cmd_resp_tx u_tx (
    .clk       (clk),
    .rst       (rst),
    .resp_data (resp_data),
    .send_resp (send_resp),
    .resp_sent (resp_sent),
    .tx_data   (tx_data),
    .trmt      (trmt),
    .tx_done   (tx_done)
  );
endmodule

// File: tb/tb_cmd_aggregator.sv
// Directed scenarios plus a randomized run against a frame-level model.
module tb_cmd_aggregator;
  localparam int TO = 8;

  logic        clk, rst;
  logic [7:0]  rx_data, resp_data, tx_data;
  logic        rx_rdy, clr_rx_rdy, cmd_rdy, clr_cmd_rdy, frame_err;
  logic        send_resp, resp_sent, trmt, tx_done;
  logic [23:0] cmd;

  int n_tests = 0, n_fail = 0;

  // reference model state: bytes of the pending frame, idle cycles since last byte
  logic [7:0]  mq[$];
  int          idle;
  bit          m_full, m_frame_err, m_trmt, m_resp_sent, m_busy;
  logic [23:0] m_cmd;
  logic [7:0]  m_tx_data;

  cmd_aggregator #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rx_rdy(clr_rx_rdy),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .frame_err(frame_err),
    .resp_data(resp_data), .send_resp(send_resp), .resp_sent(resp_sent),
    .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Advance one clock and move the model by the same edge.
  task automatic step();
    bit was_trmt;
    @(posedge clk);
    m_frame_err = 0;
    m_resp_sent = 0;
    if (rst) begin
      mq.delete(); idle = 0; m_cmd = '0; m_full = 0;
      m_busy = 0; m_trmt = 0; m_tx_data = '0;
    end else begin
      if (m_full) begin
        if (clr_cmd_rdy) m_full = 0;
      end else if (rx_rdy) begin
        mq.push_back(rx_data);
        idle = 0;
        if (mq.size() == 3) begin
          m_cmd = {mq[0], mq[1], mq[2]};
          mq.delete();
          m_full = 1;
        end
      end else if (mq.size() > 0) begin
        idle++;
        if (idle == TO) begin
          mq.delete(); idle = 0; m_frame_err = 1;
        end
      end
      was_trmt = m_trmt;
      m_trmt = 0;
      if (!m_busy) begin
        if (send_resp) begin m_tx_data = resp_data; m_trmt = 1; m_busy = 1; end
      end else if (!was_trmt && tx_done) begin
        m_busy = 0; m_resp_sent = 1;
      end
    end
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output int waited);
    rx_data = b; rx_rdy = 1'b1; waited = -1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (clr_rx_rdy === 1'b1) begin waited = i; step(); break; end
      step();
    end
    rx_rdy = 1'b0;
  endtask

  task automatic clear_cmd();
    clr_cmd_rdy = 1'b1; #1; step(); clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); #1;
    n_tests++;
    if ({clr_rx_rdy, cmd_rdy, frame_err, trmt, resp_sent} !== 5'b0 || cmd !== 24'h0 || tx_data !== 8'h0) begin
      n_fail++;
      $display("FAIL reset: got clr=%b rdy=%b err=%b trmt=%b sent=%b cmd=%h tx=%h, required all 0",
               clr_rx_rdy, cmd_rdy, frame_err, trmt, resp_sent, cmd, tx_data);
    end
    rst = 1'b0; step();
  endtask

  task automatic test_frame();
    int w0, w1, w2;
    send_byte(8'h02, w0);
    send_byte(8'h01, w1);
    #1;
    n_tests++;
    if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL frame_early: cmd_rdy=%b, required 0", cmd_rdy); end
    send_byte(8'hA5, w2);
    #1;
    n_tests++;
    if (w0 != 0 || w1 != 0 || w2 != 0) begin
      n_fail++; $display("FAIL frame_accept: waits %0d %0d %0d, required 0 0 0", w0, w1, w2);
    end
    n_tests++;
    if (cmd_rdy !== 1'b1 || cmd !== 24'h0201A5 || m_cmd !== 24'h0201A5) begin
      n_fail++; $display("FAIL frame_cmd: rdy=%b cmd=%h, required 1 0201a5", cmd_rdy, cmd);
    end
  endtask

  task automatic test_backpressure();
    int clr_seen = 0;
    int w;
    rx_data = 8'h09; rx_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1; if (clr_rx_rdy !== 1'b0) clr_seen++;
      step();
    end
    n_tests++;
    if (clr_seen != 0 || cmd_rdy !== 1'b1) begin
      n_fail++; $display("FAIL bp_hold: clr pulses=%0d rdy=%b, required 0 1", clr_seen, cmd_rdy);
    end
    clr_cmd_rdy = 1'b1; #1;
    n_tests++;
    if (clr_rx_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_clr_same: clr_rx_rdy=%b, required 0", clr_rx_rdy); end
    step(); clr_cmd_rdy = 1'b0; #1;
    n_tests++;
    if (cmd_rdy !== 1'b0 || clr_rx_rdy !== 1'b1 || cmd !== 24'h0201A5) begin
      n_fail++; $display("FAIL bp_release: rdy=%b clr=%b cmd=%h, required 0 1 0201a5", cmd_rdy, clr_rx_rdy, cmd);
    end
    step(); rx_rdy = 1'b0;
    send_byte(8'h0A, w);
    send_byte(8'h0B, w);
    #1;
    n_tests++;
    if (cmd !== 24'h090A0B || cmd !== m_cmd || cmd_rdy !== 1'b1) begin
      n_fail++; $display("FAIL bp_frame: cmd=%h rdy=%b, required 090a0b 1", cmd, cmd_rdy);
    end
    clear_cmd();
  endtask

  task automatic test_timeout();
    int w, pulses = 0, at = -1;
    send_byte(8'h03, w);
    for (int i = 1; i <= 20; i++) begin
      #1;
      if (frame_err === 1'b1) begin pulses++; at = i; end
      step();
    end
    n_tests++;
    if (pulses != 1 || at != TO + 1) begin
      n_fail++; $display("FAIL timeout_err: pulses=%0d at=%0d, required 1 at %0d", pulses, at, TO + 1);
    end
    send_byte(8'h08, w); send_byte(8'h12, w); send_byte(8'h34, w);
    #1;
    n_tests++;
    if (cmd !== 24'h081234 || cmd !== m_cmd) begin
      n_fail++; $display("FAIL timeout_resync: cmd=%h, required 081234", cmd);
    end
    clear_cmd();
  endtask

  task automatic test_expiry_accept();
    int w, errs = 0;
    send_byte(8'h03, w);
    for (int i = 1; i < TO; i++) begin
      #1; if (frame_err !== 1'b0) errs++;
      step();
    end
    rx_data = 8'h44; rx_rdy = 1'b1; #1;
    n_tests++;
    if (clr_rx_rdy !== 1'b1) begin n_fail++; $display("FAIL expiry_accept: clr_rx_rdy=%b, required 1", clr_rx_rdy); end
    step(); rx_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; if (frame_err !== 1'b0) errs++;
      step();
    end
    send_byte(8'h55, w);
    #1;
    n_tests++;
    if (errs != 0 || cmd !== 24'h034455 || cmd_rdy !== 1'b1) begin
      n_fail++; $display("FAIL expiry_frame: errs=%0d cmd=%h rdy=%b, required 0 034455 1", errs, cmd, cmd_rdy);
    end
    clear_cmd();
  endtask

  task automatic test_tx();
    int trmts = 0, sents = 0;
    resp_data = 8'hA5; send_resp = 1'b1; #1; step(); send_resp = 1'b0; #1;
    n_tests++;
    if (trmt !== 1'b1 || tx_data !== 8'hA5) begin
      n_fail++; $display("FAIL tx_start: trmt=%b tx=%h, required 1 a5", trmt, tx_data);
    end
    step();
    resp_data = 8'h5A; send_resp = 1'b1; #1; step(); send_resp = 1'b0;
    for (int i = 0; i < 18; i++) begin
      #1; if (trmt !== 1'b0) trmts++; if (resp_sent !== 1'b0) sents++;
      step();
    end
    tx_done = 1'b1; #1; step(); tx_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; if (resp_sent === 1'b1) sents++; if (trmt !== 1'b0) trmts++;
      step();
    end
    n_tests++;
    if (trmts != 0 || sents != 1 || tx_data !== 8'hA5 || m_tx_data !== 8'hA5) begin
      n_fail++; $display("FAIL tx_done: extra trmt=%0d sent=%0d tx=%h, required 0 1 a5", trmts, sents, tx_data);
    end
  endtask

  task automatic test_reset_mid();
    int w, sents = 0;
    send_byte(8'h61, w); send_byte(8'h62, w);
    resp_data = 8'hC3; send_resp = 1'b1; #1; step(); send_resp = 1'b0;
    rst = 1'b1; rx_data = 8'h77; rx_rdy = 1'b1; #1; step(); #1;
    n_tests++;
    if ({clr_rx_rdy, cmd_rdy, frame_err, trmt, resp_sent} !== 5'b0 || cmd !== 24'h0 || tx_data !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got clr=%b rdy=%b err=%b trmt=%b sent=%b cmd=%h tx=%h, required all 0",
               clr_rx_rdy, cmd_rdy, frame_err, trmt, resp_sent, cmd, tx_data);
    end
    rst = 1'b0; rx_rdy = 1'b0; tx_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; if (resp_sent !== 1'b0) sents++;
      step();
    end
    tx_done = 1'b0;
    n_tests++;
    if (sents != 0) begin n_fail++; $display("FAIL reset_no_sent: resp_sent pulses=%0d, required 0", sents); end
    send_byte(8'h11, w); send_byte(8'h22, w); send_byte(8'h33, w);
    #1;
    n_tests++;
    if (cmd !== 24'h112233 || cmd_rdy !== 1'b1) begin
      n_fail++; $display("FAIL reset_frame: cmd=%h rdy=%b, required 112233 1", cmd, cmd_rdy);
    end
    clear_cmd();
  endtask

  task automatic test_random();
    bit acc, e_clr;
    for (int c = 0; c < 2000; c++) begin
      if (!rx_rdy && $urandom_range(0, ((c / 250) % 2) ? 11 : 1) == 0) begin
        rx_rdy = 1'b1; rx_data = 8'($urandom);
      end
      clr_cmd_rdy = ($urandom_range(0, 3) == 0);
      send_resp   = ($urandom_range(0, 5) == 0);
      resp_data   = 8'($urandom);
      tx_done     = ($urandom_range(0, 3) == 0);
      #1;
      e_clr = rx_rdy && !m_full && !rst;
      n_tests++;
      if ({clr_rx_rdy, cmd_rdy, frame_err, trmt, resp_sent} !== {e_clr, m_full, m_frame_err, m_trmt, m_resp_sent}
          || cmd !== m_cmd || tx_data !== m_tx_data) begin
        n_fail++;
        $display("FAIL random cyc %0d: got clr=%b rdy=%b err=%b trmt=%b sent=%b cmd=%h tx=%h, required %b %b %b %b %b %h %h",
                 c, clr_rx_rdy, cmd_rdy, frame_err, trmt, resp_sent, cmd, tx_data,
                 e_clr, m_full, m_frame_err, m_trmt, m_resp_sent, m_cmd, m_tx_data);
      end
      acc = clr_rx_rdy;
      step();
      if (acc) rx_rdy = 1'b0;
    end
    rx_rdy = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0; tx_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_data = '0; rx_rdy = 1'b0; clr_cmd_rdy = 1'b0;
    resp_data = '0; send_resp = 1'b0; tx_done = 1'b0;
    test_reset();
    test_frame();
    test_backpressure();
    test_timeout();
    test_expiry_accept();
    test_tx();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cmd_aggregator.md
Name: cmd_aggregator

Overview:
- UART-side front end for the command processor.
- Assembles three bytes from the UART receiver into one 24-bit command and presents it with a cmd_rdy/clr_cmd_rdy handshake.
- Accepts 8-bit responses via send_resp/resp_sent and hands each byte to the UART transmitter.
- Sits between the UART rx/tx pair and the command processor. An inter-byte timeout discards partial frames so the link resynchronises after line noise.

Parameters:
TIMEOUT_CYC, 50000, clock cycles allowed between bytes of one frame before the partial frame is discarded (must be >= 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
rx_data  input  8  byte from UART receiver
rx_rdy  input  1  receiver holds a byte (level, held until cleared)
clr_rx_rdy  output  1  acknowledge/consume rx_data (combinational)
cmd  output  24  assembled command: first byte in [23:16], second in [15:8], third in [7:0]
cmd_rdy  output  1  cmd valid, level
clr_cmd_rdy  input  1  command processor has consumed cmd
frame_err  output  1  one-cycle pulse when a partial frame times out
resp_data  input  8  response byte from command processor
send_resp  input  1  request to transmit resp_data
resp_sent  output  1  one-cycle pulse when transmitter reports completion
tx_data  output  8  byte to UART transmitter
trmt  output  1  one-cycle transmit strobe
tx_done  input  1  transmitter finished (level; cleared by transmitter on the edge it samples trmt)

Behaviour:
- Reset: all outputs 0, cmd=0, partial shift register=0, timeout counter=0, both FSMs idle. Reset mid-frame or mid-transmit discards all state; no resp_sent is issued for an aborted transmit.
- RX FSM states: IDLE, GOT1, GOT2, FULL.
- Byte accept: in IDLE/GOT1/GOT2 with rx_rdy=1:
  - clr_rx_rdy=1 in the same cycle.
  - Byte captured into the partial register at that edge.
  - Timeout counter cleared.
  - State advances IDLE->GOT1->GOT2.
- Third byte (accepted in GOT2):
  - cmd <= {byte1, byte2, rx_data} at that edge.
  - cmd_rdy=1 from the next cycle; state FULL.
  - Latency: third-byte accept cycle +1.
- FULL: no bytes accepted; clr_rx_rdy=0 (back-pressure; receiver holds its byte).
- clr_cmd_rdy=1 in FULL: cmd_rdy=0 next cycle, state IDLE. cmd holds its value until the next complete frame.
- clr_cmd_rdy in FULL with rx_rdy=1 the same cycle: the clear is taken. The byte is accepted no earlier than the following cycle (IDLE).
- clr_cmd_rdy outside FULL: ignored.
- Timeout:
  - In GOT1/GOT2 the counter increments every cycle without an accept.
  - When the counter reaches TIMEOUT_CYC-1 with no accept that cycle: state IDLE, partial register cleared, frame_err=1 for the next cycle only; cmd unchanged.
  - rx_rdy in the expiry cycle: the byte wins; it is accepted and the counter is cleared.
  - Counter holds 0 in IDLE/FULL. Counter width is clog2(TIMEOUT_CYC).
- TX FSM states: TX_IDLE, TX_BUSY.
- send_resp in TX_IDLE: tx_data <= resp_data; trmt=1 for exactly the next cycle; state TX_BUSY.
- TX_BUSY:
  - tx_done is ignored while trmt=1.
  - The first later cycle with tx_done=1 gives resp_sent=1 for the next cycle and state TX_IDLE.
  - send_resp is ignored while busy.
- tx_data holds its value until the next accepted send_resp.
- The RX and TX paths are fully independent; simultaneous activity on both is legal.

Decomposition:
- Package cmd_agg_pkg holds:
  - rx_state_t enum (IDLE, GOT1, GOT2, FULL)
  - tx_state_t enum (TX_IDLE, TX_BUSY)
  - CMD_BYTES=3
  - CMD_W=24
- One sub-module, cmd_resp_tx, implements the TX FSM (send_resp/trmt/tx_done/resp_sent). The top-level holds the RX assembly and timeout logic.

Test Plan:
- Bytes 8'h02, 8'h01, 8'hA5 with rx_rdy, each held until clr_rx_rdy -> three single-cycle clr_rx_rdy; cmd=24'h0201A5; cmd_rdy rises one cycle after the third accept.
- With cmd_rdy=1, present 8'h09 on rx_rdy for 10 cycles -> clr_rx_rdy stays 0. Then assert clr_cmd_rdy together with rx_rdy -> cmd_rdy falls next cycle; byte accepted the cycle after; cmd still 24'h0201A5.
- TIMEOUT_CYC=8: send 8'h03, then idle -> frame_err pulses once, 8 cycles after the accept. Then send 8'h08, 8'h12, 8'h34 -> cmd=24'h081234 (no stale byte).
- TIMEOUT_CYC=8: second byte presented exactly in the expiry cycle -> byte accepted, no frame_err; frame completes normally.
- send_resp with resp_data=8'hA5 -> tx_data=8'hA5, one trmt pulse. Assert send_resp with 8'h5A while busy -> ignored. tx_done 20 cycles later -> one resp_sent pulse; tx_data still 8'hA5.
- Assert rst after two bytes and during TX_BUSY -> all outputs 0 the next cycle; no resp_sent; a fresh 3-byte frame assembles correctly.
